prt_slot_scheduler: RTL and testbench

Slot-lifecycle controller for the packet reference table (PRT) inside the MPD. Owns the free/busy state of every PRT slot, hands free slots to the Ethernet RX path, applies firewall verdicts (pass or invalidate), and schedules passed frames to the TX path in verdict order. It sits between the MAC RX/TX handlers, the firewall result interface and the PRT storage, and replaces ad-hoc free-slot tracking with a single arbiter.

---
 rtl/prt_slot_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_prt_slot_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/prt_slot_scheduler.sv
// prt_slot_scheduler: owns the FREE/WRITING/STORED/READING lifecycle of every
// PRT slot, grants free slots to RX, applies firewall verdicts and releases
// passed slots to TX in verdict order through a small slot-index FIFO.
module prt_slot_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              alloc_avail,
  output logic [SLOT_W-1:0] alloc_slot,
  input  logic              alloc_req,
  input  logic              wr_done,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic              fw_valid,
  input  logic [SLOT_W-1:0] fw_slot,
  input  logic              fw_pass,
  output logic              rx_abort,
  output logic              tx_valid,
  output logic [SLOT_W-1:0] tx_slot,
  input  logic              tx_ready,
  input  logic              rd_done,
  output logic [SLOT_W:0]   free_count,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_WRITING = 2'd1,
    ST_STORED  = 2'd2,
    ST_READING = 2'd3
  } slot_state_e;

  slot_state_e              state_q [NUM_SLOTS];
  slot_state_e              state_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]     passed_q, passed_d;
  logic [SLOT_W-1:0]        queue_q [NUM_SLOTS];
  logic [SLOT_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [SLOT_W:0]          count_q, count_d;
  logic                     err_q, err_d;
  logic                     rx_abort_q, rx_abort_d;

  logic [NUM_SLOTS-1:0]     free_vec_s, reading_vec_s;
  logic [NUM_SLOTS-1:0]     wr_hit_s, fw_hit_s, pop_hit_s, alloc_hit_s;
  logic [SLOT_W-1:0]        alloc_slot_s, head_slot_s;
  logic                     alloc_avail_s, alloc_fire_s;
  logic                     any_reading_s, tx_valid_s, tx_fire_s;
  logic                     verdict_ok_s, push_s, invalidate_s;
  logic                     wr_illegal_s, fw_illegal_s, rd_illegal_s, alloc_illegal_s;

  // Number of set bits; used for the FREE-slot count.
  function automatic logic [SLOT_W:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [SLOT_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n = n + (SLOT_W+1)'(v[i]);
    end
    return n;
  endfunction

  // Index of the lowest set bit, 0 when none is set.
  function automatic logic [SLOT_W-1:0] lowest_set(input logic [NUM_SLOTS-1:0] v);
    logic [SLOT_W-1:0] r;
    r = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      r = v[i] ? SLOT_W'(i) : r;
    end
    return r;
  endfunction

  // Per-slot status vectors and per-slot event decode.
  always_comb begin
    free_vec_s    = '0;
    reading_vec_s = '0;
    wr_hit_s      = '0;
    fw_hit_s      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_vec_s[i]    = (state_q[i] == ST_FREE);
      reading_vec_s[i] = (state_q[i] == ST_READING);
      wr_hit_s[i]      = wr_done  && (wr_slot == SLOT_W'(i));
      fw_hit_s[i]      = fw_valid && (fw_slot == SLOT_W'(i));
    end
  end

  // Grant, TX head and verdict qualification, all from registered state.
  always_comb begin
    alloc_avail_s = |free_vec_s;
    alloc_slot_s  = lowest_set(free_vec_s);
    alloc_fire_s  = alloc_req && alloc_avail_s;
    any_reading_s = |reading_vec_s;
    head_slot_s   = queue_q[head_q];
    // A head still WRITING blocks the queue; one READING slot blocks TX.
    tx_valid_s    = (count_q != '0) && (state_q[head_slot_s] == ST_STORED) && !any_reading_s;
    tx_fire_s     = tx_valid_s && tx_ready;
    verdict_ok_s  = ((state_q[fw_slot] == ST_WRITING) || (state_q[fw_slot] == ST_STORED))
                    && !passed_q[fw_slot];
    push_s        = fw_valid && fw_pass && verdict_ok_s;
    invalidate_s  = fw_valid && !fw_pass && verdict_ok_s;
    alloc_hit_s   = '0;
    pop_hit_s     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      alloc_hit_s[i] = alloc_fire_s && (alloc_slot_s == SLOT_W'(i));
      pop_hit_s[i]   = tx_fire_s && (head_slot_s == SLOT_W'(i));
    end
    wr_illegal_s    = wr_done && (state_q[wr_slot] != ST_WRITING);
    fw_illegal_s    = fw_valid && !verdict_ok_s;
    rd_illegal_s    = rd_done && !any_reading_s;
    alloc_illegal_s = alloc_req && !alloc_avail_s;
  end

  // Slot lifecycle next state; illegal events leave state untouched.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i]  = state_q[i];
      passed_d[i] = passed_q[i];
      case (state_q[i])
        ST_FREE: begin
          if (alloc_hit_s[i]) begin
            state_d[i]  = ST_WRITING;
            passed_d[i] = 1'b0;
          end else begin
            state_d[i]  = ST_FREE;
          end
        end
        ST_WRITING: begin
          // Invalidate wins over a same-cycle wr_done.
          if (fw_hit_s[i] && invalidate_s) begin
            state_d[i] = ST_FREE;
          end else if (wr_hit_s[i]) begin
            state_d[i] = ST_STORED;
          end else begin
            state_d[i] = ST_WRITING;
          end
          passed_d[i] = passed_q[i] | (fw_hit_s[i] & push_s);
        end
        ST_STORED: begin
          if (fw_hit_s[i] && invalidate_s) begin
            state_d[i] = ST_FREE;
          end else if (pop_hit_s[i]) begin
            state_d[i] = ST_READING;
          end else begin
            state_d[i] = ST_STORED;
          end
          passed_d[i] = passed_q[i] | (fw_hit_s[i] & push_s);
        end
        ST_READING: begin
          if (rd_done) begin
            state_d[i] = ST_FREE;
          end else begin
            state_d[i] = ST_READING;
          end
        end
        default: begin
          state_d[i] = ST_FREE;
        end
      endcase
    end
  end

  // TX queue pointers, abort pulse and sticky error next state.
  always_comb begin
    head_d     = tx_fire_s ? head_q + SLOT_W'(1) : head_q;
    tail_d     = push_s    ? tail_q + SLOT_W'(1) : tail_q;
    if (push_s && !tx_fire_s) begin
      count_d = count_q + (SLOT_W+1)'(1);
    end else if (!push_s && tx_fire_s) begin
      count_d = count_q - (SLOT_W+1)'(1);
    end else begin
      count_d = count_q;
    end
    rx_abort_d = invalidate_s && (state_q[fw_slot] == ST_WRITING);
    err_d      = err_q | wr_illegal_s | fw_illegal_s | rd_illegal_s | alloc_illegal_s;
  end

  // State register for slots, queue and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= ST_FREE;
        queue_q[i] <= '0;
      end
      passed_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      rx_abort_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
      end
      if (push_s) begin
        queue_q[tail_q] <= fw_slot;
      end
      passed_q   <= passed_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      err_q      <= err_d;
      rx_abort_q <= rx_abort_d;
    end
  end

  // Output drive.
  always_comb begin
    alloc_avail = alloc_avail_s;
    alloc_slot  = alloc_slot_s;
    tx_valid    = tx_valid_s;
    tx_slot     = head_slot_s;
    free_count  = popcount(free_vec_s);
    rx_abort    = rx_abort_q;
    err         = err_q;
  end

endmodule

// File: tb/tb_prt_slot_scheduler.sv
// Directed, table-driven bench for prt_slot_scheduler (NUM_SLOTS = 4).
module tb_prt_slot_scheduler;

  logic       clk, rst;
  logic       alloc_avail, alloc_req, wr_done, fw_valid, fw_pass;
  logic       rx_abort, tx_valid, tx_ready, rd_done, err;
  logic [1:0] alloc_slot, wr_slot, fw_slot, tx_slot;
  logic [2:0] free_count;

  int n_pass = 0;
  int n_tot  = 0;

  prt_slot_scheduler #(.NUM_SLOTS(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_avail(alloc_avail), .alloc_slot(alloc_slot), .alloc_req(alloc_req),
    .wr_done(wr_done), .wr_slot(wr_slot),
    .fw_valid(fw_valid), .fw_slot(fw_slot), .fw_pass(fw_pass),
    .rx_abort(rx_abort), .tx_valid(tx_valid), .tx_slot(tx_slot), .tx_ready(tx_ready),
    .rd_done(rd_done), .free_count(free_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       a, w, f, fp, tr, rd;
    logic [1:0] ws, fs;
    logic       e_av, e_tv, e_ab, e_err;
    logic [1:0] e_as, e_ts;
    logic [2:0] e_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(string nm, logic a, logic w, int ws, logic f, int fs, logic fp,
                     logic tr, logic rd, logic e_av, int e_as, int e_fc,
                     logic e_tv, int e_ts, logic e_ab, logic e_err);
    vec_t v;
    v.nm = nm; v.a = a; v.w = w; v.ws = 2'(ws); v.f = f; v.fs = 2'(fs); v.fp = fp;
    v.tr = tr; v.rd = rd; v.e_av = e_av; v.e_as = 2'(e_as); v.e_fc = 3'(e_fc);
    v.e_tv = e_tv; v.e_ts = 2'(e_ts); v.e_ab = e_ab; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic idle_inputs();
    alloc_req = 1'b0; wr_done = 1'b0; wr_slot = 2'd0; fw_valid = 1'b0;
    fw_slot = 2'd0; fw_pass = 1'b0; tx_ready = 1'b0; rd_done = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, ".alloc_avail"}, 32'(alloc_avail), 32'd1);
    chk({tag, ".alloc_slot"},  32'(alloc_slot),  32'd0);
    chk({tag, ".free_count"},  32'(free_count),  32'd4);
    chk({tag, ".tx_valid"},    32'(tx_valid),    32'd0);
    chk({tag, ".tx_slot"},     32'(tx_slot),     32'd0);
    chk({tag, ".rx_abort"},    32'(rx_abort),    32'd0);
    chk({tag, ".err"},         32'(err),         32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //   name          a  w ws f fs fp tr rd | av as fc tv ts ab err
    add("alloc0",      1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 3, 0, 0, 0, 0);
    add("alloc1",      1, 0, 0, 0, 0, 0, 0, 0,  1, 2, 2, 0, 0, 0, 0);
    add("alloc2",      1, 0, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0);
    add("alloc3",      1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add("wr0",         0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add("pass0",       0, 0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    add("txpop0",      0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    add("rd0",         0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 0, 0, 0);
    add("realloc0",    1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add("inval0",      0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 0);
    add("abortend",    0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    add("wr2",         0, 1, 2, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    add("pass1wr",     0, 0, 0, 1, 1, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    add("pass2st",     0, 0, 0, 1, 2, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    add("wr1unblk",    0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 1, 1, 1, 0, 0);
    add("txpop1",      0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 0);
    add("rd1",         0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 2, 1, 2, 0, 0);
    add("txpop2",      0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 2, 0, 0, 0, 0);
    add("rd2",         0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 3, 0, 0, 0, 0);
    add("allocA",      1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 2, 0, 0, 0, 0);
    add("allocB",      1, 0, 0, 0, 0, 0, 0, 0,  1, 2, 1, 0, 0, 0, 0);
    add("wr1st",       0, 1, 1, 0, 0, 0, 0, 0,  1, 2, 1, 0, 0, 0, 0);
    add("simul3",      1, 1, 0, 1, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0);
    add("simulidle",   0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0);
    add("wrinval2",    0, 1, 2, 1, 2, 0, 0, 0,  1, 1, 2, 0, 0, 1, 0);
    add("wrpass3",     0, 1, 3, 1, 3, 1, 0, 0,  1, 1, 2, 1, 3, 0, 0);
    add("idle3",       0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 2, 1, 3, 0, 0);
    add("wrfree1",     0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 2, 1, 3, 0, 1);
    add("errsticky",   0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 2, 1, 3, 0, 1);

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      alloc_req = vecs[k].a;  wr_done = vecs[k].w;   wr_slot = vecs[k].ws;
      fw_valid  = vecs[k].f;  fw_slot = vecs[k].fs;  fw_pass = vecs[k].fp;
      tx_ready  = vecs[k].tr; rd_done = vecs[k].rd;
      @(posedge clk);
      #1;
      idle_inputs();
      chk({vecs[k].nm, ".alloc_avail"}, 32'(alloc_avail), 32'(vecs[k].e_av));
      if (vecs[k].e_av) chk({vecs[k].nm, ".alloc_slot"}, 32'(alloc_slot), 32'(vecs[k].e_as));
      chk({vecs[k].nm, ".free_count"}, 32'(free_count), 32'(vecs[k].e_fc));
      chk({vecs[k].nm, ".tx_valid"},   32'(tx_valid),   32'(vecs[k].e_tv));
      if (vecs[k].e_tv) chk({vecs[k].nm, ".tx_slot"}, 32'(tx_slot), 32'(vecs[k].e_ts));
      chk({vecs[k].nm, ".rx_abort"},   32'(rx_abort),   32'(vecs[k].e_ab));
      chk({vecs[k].nm, ".err"},        32'(err),        32'(vecs[k].e_err));
    end

    // Slot 3 into READING, then reset mid-transfer without a clock edge.
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    chk("pop3.tx_valid", 32'(tx_valid), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill all slots, checking the grant offered before each edge.
    for (int k = 0; k < 4; k++) begin
      alloc_req = 1'b1;
      chk("fill.alloc_slot", 32'(alloc_slot), 32'(k));
      @(posedge clk);
      #1;
      alloc_req = 1'b0;
    end
    chk("full.alloc_avail", 32'(alloc_avail), 32'd0);
    chk("full.free_count",  32'(free_count),  32'd0);

    // Request while nothing is free is illegal.
    alloc_req = 1'b1;
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
    chk("allocfull.err",        32'(err),        32'd1);
    chk("allocfull.free_count", 32'(free_count), 32'd0);

    // Invalidate slot 2: freed slot must not show up in the same cycle.
    fw_valid = 1'b1; fw_slot = 2'd2; fw_pass = 1'b0;
    #1;
    chk("freeN.alloc_avail", 32'(alloc_avail), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("freeN1.alloc_avail", 32'(alloc_avail), 32'd1);
    chk("freeN1.alloc_slot",  32'(alloc_slot),  32'd2);
    chk("freeN1.free_count",  32'(free_count),  32'd1);
    chk("freeN1.rx_abort",    32'(rx_abort),    32'd1);
    @(posedge clk);
    #1;
    chk("freeN2.rx_abort", 32'(rx_abort), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
